piso_bit_serializer: RTL
========================

Name: piso_bit_serializer

Overview:
- Parallel-in/serial-out stage directly upstream of the serial 1010 sequence detector; produces the one-bit-per-cycle stream that the detector samples on its `i` input.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per enabled cycle, back-to-back with no gap bits.
- Qualifies each bit with bit_valid and flags the final bit of every word.

Parameters:
- WIDTH, 8: word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 = din[WIDTH-1] is sent first; 0 = din[0] is sent first.
- IDLE_BIT, 1'b0: level driven on sout while no word is being sent.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- din  input  WIDTH  parallel word; sampled only on a handshake.
- din_valid  input  1  upstream has a word on din.
- din_ready  output  1  block can accept din this cycle.
- bit_en  input  1  bit-rate strobe; the shifter advances only when high.
- sout  output  1  serial bit; connects to the detector's i input.
- bit_valid  output  1  sout carries a data bit.
- last_bit  output  1  sout is the final bit of the current word.
- busy  output  1  a word is in progress.

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE, sreg=0, cnt=0, sout=IDLE_BIT, bit_valid=0, last_bit=0, busy=0. din_ready=1 once rst is low.
- Handshake: a transfer occurs on a rising edge when din_valid and din_ready are both high. din is not sampled otherwise. din_valid high while din_ready is low is held off; the word is not lost or consumed.
- State IDLE:
  - din_ready=1, sout=IDLE_BIT, bit_valid=0, busy=0.
  - On transfer: load sreg=din and cnt=WIDTH-1, then go to SHIFT.
  - bit_en is ignored for the load.
- State SHIFT:
  - bit_valid=1, busy=1.
  - sout=sreg[WIDTH-1] when MSB_FIRST=1; sout=sreg[0] when MSB_FIRST=0.
  - last_bit=(cnt==0).
- Advance in SHIFT (bit_en=1 and cnt!=0): shift sreg toward the output end with zero fill; decrement cnt.
- Hold in SHIFT (bit_en=0): sreg, cnt, sout, bit_valid and last_bit all hold.
- din_ready in SHIFT = (cnt==0) and bit_en.
- End of word (cnt==0 and bit_en=1):
  - With transfer: reload sreg=din and cnt=WIDTH-1, stay in SHIFT. No gap bit, and bit_valid stays high.
  - Without transfer: go to IDLE.
- Latency: with a transfer at edge N and bit_en held at 1, bit k (k=0..WIDTH-1) appears on sout during the cycle after edge N+k. The word occupies exactly WIDTH cycles.
- Registered outputs: sout, bit_valid and last_bit are decoded from registered state only (Moore style). No combinational path from din or din_valid to sout.
- Combinational output: din_ready is combinational from state, cnt and bit_en. It does not depend on din_valid.
- Counter: cnt is ceil(log2(WIDTH)) bits wide, unsigned. It never wraps below 0; the cnt==0 branch always reloads or exits.
- Reset mid-word: the word in flight is discarded immediately (asynchronous), outputs take reset values, and no partial word is resumed.
- Undefined state encoding: recover to IDLE on the next edge, with outputs at IDLE values.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=1'b0 and ST_SHIFT=1'b1;
  - a clog2-based width function for cnt, so the detector bench and this block share one definition.
- No sub-module. The shift register, down-counter and two-state FSM stay in one module of roughly 150 lines.

Test Plan:
- Single word, MSB_FIRST=1, WIDTH=8, din=8'hA5, bit_en=1:
  - sout=1,0,1,0,0,1,0,1 on cycles N+1..N+8;
  - last_bit high only on cycle N+8; bit_valid low and sout=0 from cycle N+9.
- Back-to-back 8'h0A then 8'h0A, din_valid held high:
  - 16 contiguous valid bits 0000101000001010;
  - din_ready high exactly on the two last-bit cycles and in IDLE;
  - a chained 1010 detector reaches its terminal state twice.
- Stall: din=8'hF0, bit_en toggling 1,0,1,0…:
  - each bit holds for 2 cycles and the bit sequence is unchanged;
  - din_ready never high while bit_en=0.
- Hold-off: din_valid asserted on cycle N+3 of a word with din=8'h3C:
  - the word is not consumed until the last-bit cycle;
  - 8'h3C then follows with no gap and is not duplicated.
- LSB_FIRST (MSB_FIRST=0), din=8'h01: sout=1,0,0,0,0,0,0,0.
- Reset mid-word: assert rst asynchronously (mid-cycle) on cycle N+4 of 8'hA5:
  - outputs go to reset values immediately;
  - after release, a new 8'h55 word serializes correctly with no leftover bits.

Source files
------------

// File: rtl/piso_bit_serializer_pkg.sv
// Shared definitions for the PISO bit serializer and its consumers.
// Holds the two-state FSM encoding and the counter width helper so the
// downstream detector bench and this block agree on one definition.
package piso_bit_serializer_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    typedef enum logic {
        StIdle  = ST_IDLE,
        StShift = ST_SHIFT
    } state_e;

    // Bits needed for a down-counter spanning 0..width-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_bit_serializer_if.sv
// Handshake and serial-stream bundle for the PISO bit serializer.
//   din/din_valid/din_ready : parallel word handshake (master drives din, din_valid)
//   bit_en                  : bit-rate strobe from the master side
//   sout/bit_valid/last_bit : serial bit stream toward the detector
//   busy                    : a word is in progress
interface piso_bit_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             bit_en;
    logic             sout;
    logic             bit_valid;
    logic             last_bit;
    logic             busy;

    modport master (
        output din, din_valid, bit_en,
        input  din_ready, sout, bit_valid, last_bit, busy
    );

    modport slave (
        input  din, din_valid, bit_en,
        output din_ready, sout, bit_valid, last_bit, busy
    );
endinterface

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out serializer feeding the serial 1010 detector.
// Accepts WIDTH-bit words on a valid/ready handshake and shifts them out one
// bit per bit_en cycle, back-to-back with no gap bits.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : slave modport of piso_bit_serializer_if (din, din_valid, din_ready,
//         bit_en, sout, bit_valid, last_bit, busy)
module piso_bit_serializer
    import piso_bit_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter logic        IDLE_BIT  = 1'b0
) (
    input logic                   clk,
    input logic                   rst,
    piso_bit_serializer_if.slave  bus
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    state_e           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             cnt_zero;
    logic             xfer;
    logic [WIDTH-1:0] sreg_shifted;

    assign cnt_zero = (cnt == '0);
    assign xfer     = bus.din_valid & bus.din_ready;

    // Move the next bit toward whichever end drives sout, zero filling behind.
    assign sreg_shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

    // Ready only while idle or when the final bit is being consumed this cycle,
    // so a reload lands exactly where the next bit would have been.
    always_comb begin
        bus.din_ready = 1'b0;
        case (state)
            StIdle:  bus.din_ready = 1'b1;
            StShift: bus.din_ready = cnt_zero & bus.bit_en;
            default: bus.din_ready = 1'b0;
        endcase
    end

    // Moore outputs decoded only from registered state.
    always_comb begin
        bus.sout      = IDLE_BIT;
        bus.bit_valid = 1'b0;
        bus.last_bit  = 1'b0;
        bus.busy      = 1'b0;
        if (state == StShift) begin
            bus.sout      = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
            bus.bit_valid = 1'b1;
            bus.last_bit  = cnt_zero;
            bus.busy      = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= StIdle;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                StIdle: begin
                    // bit_en plays no part in the initial load.
                    if (xfer) begin
                        sreg  <= bus.din;
                        cnt   <= CNT_MAX;
                        state <= StShift;
                    end
                end
                StShift: begin
                    if (bus.bit_en) begin
                        if (!cnt_zero) begin
                            sreg <= sreg_shifted;
                            cnt  <= cnt - 1'b1;
                        end else if (xfer) begin
                            sreg <= bus.din;
                            cnt  <= CNT_MAX;
                        end else begin
                            state <= StIdle;
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                    sreg  <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
